// File: rtl/scurve_scan_engine.sv
// S-curve threshold scan engine: steps the DAC over a range for one or all channels,
// counts triggers in a CLK_EXT-timed window and streams framed results out.
module scurve_scan_engine #(
  parameter int NCHN        = 64,
  parameter int CHN_W       = 6,
  parameter int DAC_W       = 10,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 16,
  parameter int CFG_TIMEOUT = 65535
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Test_Start,
  input  logic             Scan_All,
  input  logic [CHN_W-1:0] Single_Chn,
  input  logic             Ctest_or_Input,
  input  logic [1:0]       Trig_Sel,
  input  logic [DAC_W-1:0] DAC_Start,
  input  logic [DAC_W-1:0] DAC_Stop,
  input  logic [DAC_W-1:0] DAC_Step,
  input  logic [CNT_W-1:0] CPT_MAX,
  output logic [NCHN-1:0]  CTest_Chn_Out,
  output logic [DAC_W-1:0] DAC_Out,
  output logic             Param_Load,
  input  logic             Config_Done,
  input  logic             CLK_EXT,
  input  logic             out_trigger0b,
  input  logic             out_trigger1b,
  input  logic             out_trigger2b,
  output logic [15:0]      Data_Out,
  output logic             Data_Valid,
  input  logic             Data_Ready,
  output logic             Busy,
  output logic             Test_Done
);

  typedef enum logic [3:0] {
    S_IDLE, S_HEADER, S_LOAD, S_WAIT_CFG, S_SETTLE, S_COUNT,
    S_EMIT, S_NEXT, S_TRAILER, S_ABORT, S_DONE
  } state_t;

  state_t           state;
  logic             start_d;
  logic             scan_all, ctest;
  logic [1:0]       trig_sel;
  logic [CHN_W-1:0] chn;
  logic [DAC_W-1:0] dac, dac_start, dac_stop, dac_step;
  logic [CNT_W-1:0] cpt_max, win_cnt, trig_cnt;
  logic [31:0]      timer;
  logic [1:0]       emit_idx;

  logic [1:0] ext_sync, t0_sync, t1_sync, t2_sync;
  logic       ext_prev, trig_prev, trig_src;
  logic       ext_evt, trig_evt, start_rise, can_push, more_chn;
  logic [DAC_W:0]  next_dac;
  logic [NCHN-1:0] mask_cur;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ext_sync  <= '0;
      ext_prev  <= 1'b0;
      t0_sync   <= '1;
      t1_sync   <= '1;
      t2_sync   <= '1;
      trig_prev <= 1'b1;
    end else begin
      ext_sync  <= {ext_sync[0], CLK_EXT};
      ext_prev  <= ext_sync[1];
      t0_sync   <= {t0_sync[0], out_trigger0b};
      t1_sync   <= {t1_sync[0], out_trigger1b};
      t2_sync   <= {t2_sync[0], out_trigger2b};
      trig_prev <= trig_src;
    end
  end

  always_comb begin
    trig_src = 1'b1;
    case (trig_sel)
      2'd0:    trig_src = t0_sync[1];
      2'd1:    trig_src = t1_sync[1];
      2'd2:    trig_src = t2_sync[1];
      default: trig_src = t0_sync[1] & t1_sync[1] & t2_sync[1];
    endcase
  end

  assign ext_evt    = ext_sync[1] & ~ext_prev;
  assign trig_evt   = trig_prev & ~trig_src;
  assign start_rise = Test_Start & ~start_d;
  assign can_push   = ~Data_Valid | Data_Ready;
  assign next_dac   = {1'b0, dac} + {1'b0, dac_step};
  assign more_chn   = scan_all && (chn < CHN_W'(NCHN - 1));
  assign mask_cur   = (scan_all || ctest) ? (NCHN'(1) << chn) : '0;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      start_d       <= 1'b0;
      scan_all      <= 1'b0;
      ctest         <= 1'b0;
      trig_sel      <= '0;
      chn           <= '0;
      dac           <= '0;
      dac_start     <= '0;
      dac_stop      <= '0;
      dac_step      <= '0;
      cpt_max       <= '0;
      win_cnt       <= '0;
      trig_cnt      <= '0;
      timer         <= '0;
      emit_idx      <= '0;
      CTest_Chn_Out <= '0;
      DAC_Out       <= '0;
      Param_Load    <= 1'b0;
      Data_Out      <= '0;
      Data_Valid    <= 1'b0;
      Busy          <= 1'b0;
      Test_Done     <= 1'b0;
    end else begin
      start_d    <= Test_Start;
      Param_Load <= 1'b0;
      // A push in an emitting state below overrides this release.
      if (Data_Valid && Data_Ready) Data_Valid <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            scan_all  <= Scan_All;
            ctest     <= Ctest_or_Input;
            trig_sel  <= Trig_Sel;
            chn       <= Scan_All ? '0 : Single_Chn;
            dac       <= DAC_Start;
            dac_start <= DAC_Start;
            dac_stop  <= DAC_Stop;
            dac_step  <= (DAC_Step == '0) ? DAC_W'(1) : DAC_Step;
            cpt_max   <= CPT_MAX;
            Test_Done <= 1'b0;
            Busy      <= 1'b1;
            state     <= S_HEADER;
          end
        end
        S_HEADER: if (can_push) begin
          Data_Out   <= 16'hFF45;
          Data_Valid <= 1'b1;
          state      <= (dac_start > dac_stop) ? S_TRAILER : S_LOAD;
        end
        S_LOAD: begin
          DAC_Out       <= dac;
          CTest_Chn_Out <= mask_cur;
          Param_Load    <= 1'b1;
          timer         <= '0;
          state         <= S_WAIT_CFG;
        end
        S_WAIT_CFG: begin
          if (Config_Done) begin
            timer <= '0;
            state <= S_SETTLE;
          end else if (timer == 32'(CFG_TIMEOUT - 1)) begin
            state <= S_ABORT;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_SETTLE: begin
          if (timer >= 32'(SETTLE_CYC - 1)) begin
            win_cnt  <= '0;
            trig_cnt <= '0;
            state    <= S_COUNT;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_COUNT: begin
          if (win_cnt == cpt_max) begin
            emit_idx <= '0;
            state    <= S_EMIT;
          end else begin
            if (ext_evt) win_cnt <= win_cnt + CNT_W'(1);
            if (trig_evt && trig_cnt != '1) trig_cnt <= trig_cnt + CNT_W'(1);
          end
        end
        S_EMIT: if (can_push) begin
          Data_Valid <= 1'b1;
          case (emit_idx)
            2'd0:    Data_Out <= 16'(chn);
            2'd1:    Data_Out <= 16'(dac);
            default: Data_Out <= 16'(trig_cnt);
          endcase
          if (emit_idx == 2'd2) state <= S_NEXT;
          else emit_idx <= emit_idx + 2'd1;
        end
        S_NEXT: begin
          // Carry out of the DAC_W+1 bit sum means the code would wrap: end of range.
          if (!next_dac[DAC_W] && next_dac[DAC_W-1:0] <= dac_stop) begin
            dac   <= next_dac[DAC_W-1:0];
            state <= S_LOAD;
          end else if (more_chn) begin
            chn   <= chn + CHN_W'(1);
            dac   <= dac_start;
            state <= S_LOAD;
          end else begin
            state <= S_TRAILER;
          end
        end
        S_TRAILER, S_ABORT: if (can_push) begin
          Data_Out      <= (state == S_TRAILER) ? 16'hFF46 : 16'hFFEE;
          Data_Valid    <= 1'b1;
          Busy          <= 1'b0;
          Test_Done     <= 1'b1;
          CTest_Chn_Out <= '0;
          state         <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scurve_scan_engine.sv
// Directed bench for scurve_scan_engine: config-block and trigger models drive the DUT,
// the output stream, masks and DAC codes are compared against expected frames.
module tb_scurve_scan_engine;
  localparam int NCHN = 8, CHN_W = 3, DAC_W = 10;

  logic             Clk = 1'b0, reset = 1'b1, CLK_EXT = 1'b0;
  logic             Test_Start = 1'b0, Scan_All = 1'b0, Ctest_or_Input = 1'b0;
  logic [CHN_W-1:0] Single_Chn = '0;
  logic [1:0]       Trig_Sel = '0;
  logic [DAC_W-1:0] DAC_Start = '0, DAC_Stop = '0, DAC_Step = '0;
  logic [15:0]      CPT_MAX = '0;
  logic             Config_Done = 1'b0, Data_Ready = 1'b1;
  logic             out_trigger0b = 1'b1, out_trigger1b = 1'b1, out_trigger2b = 1'b1;
  logic [NCHN-1:0]  CTest_Chn_Out, s_mask;
  logic [DAC_W-1:0] DAC_Out, s_dac;
  logic [15:0]      Data_Out, s_out;
  logic [7:0]       s_cpt;
  logic             Param_Load, Data_Valid, Busy, Test_Done;
  logic             s_pl, s_valid, s_busy, s_done;

  int checks = 0, errors = 0;
  bit cfg_en = 1'b1;
  int ntrig = 0, tline = 0;
  logic [15:0]      words[$], sat_words[$];
  logic [NCHN-1:0]  masks[$];
  logic [DAC_W-1:0] dacs[$];

  always #5 Clk = ~Clk;
  always #50 CLK_EXT = ~CLK_EXT;
  assign s_cpt = CPT_MAX[7:0];

  scurve_scan_engine #(.NCHN(NCHN), .CHN_W(CHN_W), .DAC_W(DAC_W), .CNT_W(16),
                       .SETTLE_CYC(4), .CFG_TIMEOUT(100)) u_dut (
    .Clk(Clk), .reset(reset), .Test_Start(Test_Start), .Scan_All(Scan_All),
    .Single_Chn(Single_Chn), .Ctest_or_Input(Ctest_or_Input), .Trig_Sel(Trig_Sel),
    .DAC_Start(DAC_Start), .DAC_Stop(DAC_Stop), .DAC_Step(DAC_Step), .CPT_MAX(CPT_MAX),
    .CTest_Chn_Out(CTest_Chn_Out), .DAC_Out(DAC_Out), .Param_Load(Param_Load),
    .Config_Done(Config_Done), .CLK_EXT(CLK_EXT), .out_trigger0b(out_trigger0b),
    .out_trigger1b(out_trigger1b), .out_trigger2b(out_trigger2b), .Data_Out(Data_Out),
    .Data_Valid(Data_Valid), .Data_Ready(Data_Ready), .Busy(Busy), .Test_Done(Test_Done));

  // Narrow-counter twin, used to show trigger-count saturation with a short run.
  scurve_scan_engine #(.NCHN(NCHN), .CHN_W(CHN_W), .DAC_W(DAC_W), .CNT_W(8),
                       .SETTLE_CYC(4), .CFG_TIMEOUT(100)) u_sat (
    .Clk(Clk), .reset(reset), .Test_Start(Test_Start), .Scan_All(Scan_All),
    .Single_Chn(Single_Chn), .Ctest_or_Input(Ctest_or_Input), .Trig_Sel(Trig_Sel),
    .DAC_Start(DAC_Start), .DAC_Stop(DAC_Stop), .DAC_Step(DAC_Step), .CPT_MAX(s_cpt),
    .CTest_Chn_Out(s_mask), .DAC_Out(s_dac), .Param_Load(s_pl),
    .Config_Done(Config_Done), .CLK_EXT(CLK_EXT), .out_trigger0b(out_trigger0b),
    .out_trigger1b(out_trigger1b), .out_trigger2b(out_trigger2b), .Data_Out(s_out),
    .Data_Valid(s_valid), .Data_Ready(Data_Ready), .Busy(s_busy), .Test_Done(s_done));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Data_Valid && Data_Ready) words.push_back(Data_Out);
    if (s_valid && Data_Ready) sat_words.push_back(s_out);
    if (Param_Load) begin
      masks.push_back(CTest_Chn_Out);
      dacs.push_back(DAC_Out);
    end
  end

  task automatic set_trig(input logic v);
    case (tline)
      0:       out_trigger0b = v;
      1:       out_trigger1b = v;
      default: out_trigger2b = v;
    endcase
  endtask

  // Config block: acknowledge each reload, then fire a trigger train into the window.
  initial begin
    forever begin
      @(negedge Clk);
      if (Param_Load && cfg_en) begin
        repeat (3) @(negedge Clk);
        Config_Done = 1'b1;
        @(negedge Clk);
        Config_Done = 1'b0;
        fork
          begin
            #190;
            for (int i = 0; i < ntrig; i++) begin
              set_trig(1'b0); #20;
              set_trig(1'b1); #20;
            end
          end
        join_none
      end
    end
  end

  task automatic start_pulse();
    @(posedge Clk); #1 Test_Start = 1'b1;
    @(posedge Clk); #1 Test_Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!Test_Done && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check({tag, " done"}, 32'(Test_Done), 32'd1);
    repeat (3) @(negedge Clk);
  endtask

  task automatic run_scan(input string tag, input bit all, input int chn, input int ctest,
                          input int tsel, input int dstart, input int dstop, input int dstep,
                          input int cpt, input int nt, input int tl, input int budget);
    logic [15:0]      exp[$];
    logic [NCHN-1:0]  expm[$];
    logic [DAC_W-1:0] expd[$];
    logic [NCHN-1:0]  m;
    int step, cnt, c0, c1;
    repeat (60) @(negedge Clk);
    Scan_All = all; Single_Chn = CHN_W'(chn); Ctest_or_Input = ctest[0];
    Trig_Sel = 2'(tsel); DAC_Start = DAC_W'(dstart); DAC_Stop = DAC_W'(dstop);
    DAC_Step = DAC_W'(dstep); CPT_MAX = 16'(cpt); ntrig = nt; tline = tl;
    words.delete(); sat_words.delete(); masks.delete(); dacs.delete();
    start_pulse();
    wait_done(tag, budget);
    step = (dstep == 0) ? 1 : dstep;
    cnt  = (cpt == 0 || !(tsel == 3 || tsel == tl)) ? 0 : ((nt > 65535) ? 65535 : nt);
    exp.push_back(16'hFF45);
    if (dstart <= dstop) begin
      c0 = all ? 0 : chn;
      c1 = all ? NCHN - 1 : chn;
      for (int c = c0; c <= c1; c++)
        for (int d = dstart; d <= dstop; d += step) begin
          exp.push_back(16'(c)); exp.push_back(16'(d)); exp.push_back(16'(cnt));
          m = NCHN'(1) << c;
          expm.push_back((all || ctest != 0) ? m : '0);
          expd.push_back(DAC_W'(d));
        end
    end
    exp.push_back(16'hFF46);
    check({tag, " nwords"}, 32'(words.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < words.size(); i++)
      check($sformatf("%s word%0d", tag, i), 32'(words[i]), 32'(exp[i]));
    check({tag, " nloads"}, 32'(masks.size()), 32'(expm.size()));
    for (int i = 0; i < expm.size() && i < masks.size(); i++) begin
      check($sformatf("%s mask%0d", tag, i), 32'(masks[i]), 32'(expm[i]));
      check($sformatf("%s dac%0d", tag, i), 32'(dacs[i]), 32'(expd[i]));
    end
    check({tag, " busy"}, 32'(Busy), 32'd0);
    check({tag, " mask idle"}, 32'(CTest_Chn_Out), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 32'(Busy), 32'd0);
    check({tag, " done"}, 32'(Test_Done), 32'd0);
    check({tag, " valid"}, 32'(Data_Valid), 32'd0);
    check({tag, " data"}, 32'(Data_Out), 32'd0);
    check({tag, " mask"}, 32'(CTest_Chn_Out), 32'd0);
    check({tag, " dac"}, 32'(DAC_Out), 32'd0);
    check({tag, " pload"}, 32'(Param_Load), 32'd0);
  endtask

  initial begin
    int n, unstable;
    logic [15:0] held;
    logic        hv;
    #1 check_zero("reset");
    repeat (3) @(posedge Clk);
    #2 reset = 1'b0;

    run_scan("single",  1'b0, 5, 1, 0, 100, 102, 1, 10, 4, 0, 3000);
    run_scan("allch",   1'b1, 0, 0, 1, 0, 1023, 512, 5, 2, 1, 5000);
    run_scan("nowrap",  1'b0, 3, 0, 2, 1020, 1023, 8, 4, 1, 2, 2000);
    run_scan("empty",   1'b0, 0, 1, 3, 5, 3, 1, 4, 0, 0, 500);
    run_scan("cpt0",    1'b0, 7, 1, 3, 7, 8, 0, 0, 3, 1, 500);
    run_scan("selmiss", 1'b0, 4, 1, 0, 40, 40, 1, 10, 4, 1, 3000);

    // Back-pressure mid-EMIT, with enough triggers to saturate the 8-bit twin.
    fork
      run_scan("bp", 1'b0, 2, 1, 3, 20, 21, 1, 150, 300, 0, 8000);
      begin
        n = 0;
        while (!Busy && n < 200) begin @(negedge Clk); n++; end
        while (!(Data_Valid && Data_Out == 16'h0002) && n < 5000) begin @(negedge Clk); n++; end
        @(posedge Clk); #1 Data_Ready = 1'b0;
        @(negedge Clk);
        held = Data_Out; hv = Data_Valid; unstable = 0;
        repeat (20) begin
          @(negedge Clk);
          if (Data_Out !== held || Data_Valid !== 1'b1) unstable++;
        end
        check("bp held valid", 32'(hv), 32'd1);
        check("bp held word", 32'(held), 32'd20);
        check("bp unstable cycles", 32'(unstable), 32'd0);
        @(posedge Clk); #1 Data_Ready = 1'b1;
      end
    join
    check("sat nwords", 32'(sat_words.size()), 32'd8);
    if (sat_words.size() == 8) begin
      check("sat cnt0", 32'(sat_words[3]), 32'h00FF);
      check("sat cnt1", 32'(sat_words[6]), 32'h00FF);
    end

    // Config never acknowledged: abort after 100 cycles; a start edge while busy is ignored.
    repeat (60) @(negedge Clk);
    cfg_en = 1'b0; Scan_All = 1'b0; Single_Chn = 3'd1; DAC_Start = 10'd9; DAC_Stop = 10'd9;
    words.delete();
    start_pulse();
    n = 0;
    while (!Param_Load && n < 100) begin @(negedge Clk); n++; end
    check("tmo pload", 32'(Param_Load), 32'd1);
    start_pulse();
    repeat (93) @(negedge Clk);
    check("tmo early", 32'(Test_Done), 32'd0);
    wait_done("tmo", 30);
    check("tmo nwords", 32'(words.size()), 32'd2);
    if (words.size() == 2) begin
      check("tmo w0", 32'(words[0]), 32'hFF45);
      check("tmo w1", 32'(words[1]), 32'hFFEE);
    end
    cfg_en = 1'b1;

    // Reset during COUNT, then a clean scan.
    repeat (60) @(negedge Clk);
    CPT_MAX = 16'd150; ntrig = 2; tline = 0; Trig_Sel = 2'd0;
    start_pulse();
    n = 0;
    while (!Param_Load && n < 100) begin @(negedge Clk); n++; end
    repeat (40) @(negedge Clk);
    words.delete();
    @(posedge Clk); #2 reset = 1'b1;
    #1 check_zero("midrst");
    repeat (3) @(posedge Clk);
    #2 reset = 1'b0;
    repeat (50) @(negedge Clk);
    check("midrst nwords", 32'(words.size()), 32'd0);
    check("midrst idle busy", 32'(Busy), 32'd0);
    run_scan("postrst", 1'b0, 6, 1, 0, 50, 51, 1, 10, 4, 0, 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scurve_scan_engine.md
Name: scurve_scan_engine

Overview:
- Parametrised successor to the fixed 64-channel, 10-bit S-curve test top.
- Performs S-curve threshold scans over a programmable DAC range with a programmable step, for one channel or all NCHN channels.
- Count window, trigger counting and output formatting are integrated, so no external scurve data FIFO is needed. Results stream to the USB data FIFO path over a valid/ready handshake.
- Sits between the slow-control/Microroc config block and the USB data FIFO writer.

Parameters:
- NCHN, 64, number of channels scanned in all-channel mode.
- CHN_W, 6, channel index width; must satisfy 2^CHN_W >= NCHN and CHN_W <= 16.
- DAC_W, 10, threshold DAC width; must be <= 16.
- CNT_W, 16, width of the window counter and the trigger counter; must be <= 16.
- SETTLE_CYC, 16, Clk cycles waited after Config_Done before each count window opens.
- CFG_TIMEOUT, 65535, Clk cycles to wait for Config_Done before aborting.

Ports:
- Clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Test_Start  in  1  level input; a rising edge starts a scan.
- Scan_All  in  1  0 = single channel, 1 = channels 0..NCHN-1.
- Single_Chn  in  CHN_W  channel used in single-channel mode.
- Ctest_or_Input  in  1  single-channel mode only: 1 = inject through Ctest, 0 = inject through the input pin.
- Trig_Sel  in  2  trigger source: 0 = out_trigger0b, 1 = out_trigger1b, 2 = out_trigger2b, 3 = any of the three.
- DAC_Start  in  DAC_W  first threshold code.
- DAC_Stop  in  DAC_W  last threshold code, inclusive.
- DAC_Step  in  DAC_W  threshold increment.
- CPT_MAX  in  CNT_W  count window length in CLK_EXT rising edges.
- CTest_Chn_Out  out  NCHN  Ctest enable mask.
- DAC_Out  out  DAC_W  threshold code for the current point.
- Param_Load  out  1  one-cycle request to reload Microroc slow control.
- Config_Done  in  1  pulse or level from the config block indicating reload complete.
- CLK_EXT  in  1  asynchronous external reference clock.
- out_trigger0b / out_trigger1b / out_trigger2b  in  1 each  asynchronous, active-low triggers.
- Data_Out  out  16  result word.
- Data_Valid  out  1  Data_Out is valid.
- Data_Ready  in  1  downstream accepts the word (typically the inverse of FIFO full).
- Busy  out  1  scan in progress.
- Test_Done  out  1  scan finished; held high until the next start.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Input synchronisation:
  - CLK_EXT and all three triggers pass through 2-flop synchronisers.
  - A CLK_EXT event is a synchronised 0->1 transition.
  - A trigger event is a synchronised 1->0 transition on the selected source. With Trig_Sel = 3, the source is the AND of the three active-low lines.
- Start:
  - Rising edge of Test_Start in IDLE or DONE latches all configuration inputs, clears Test_Done, sets Busy and goes to HEADER.
  - A Test_Start edge while Busy is ignored.
  - A DAC_Step value of 0 is treated as 1.
- Channel and mask:
  - Channel counter starts at Single_Chn in single mode, or at 0 in all-channel mode.
  - CTest_Chn_Out is one-hot at the current channel. In single mode with Ctest_or_Input = 0 it is all zeros.
  - CTest_Chn_Out returns to 0 in IDLE and DONE.
- State machine:
  - HEADER: emit 16'hFF45, then go to LOAD. If DAC_Start > DAC_Stop, go directly to TRAILER instead.
  - LOAD: drive DAC_Out and CTest_Chn_Out for the current point, assert Param_Load for exactly 1 cycle, then go to WAIT_CFG.
  - WAIT_CFG: on Config_Done = 1, go to SETTLE. After CFG_TIMEOUT cycles without Config_Done, go to ABORT.
  - SETTLE: wait SETTLE_CYC cycles, clear both counters, then go to COUNT.
  - COUNT:
    - Each CLK_EXT event increments the window counter; each trigger event increments the trigger counter.
    - The trigger counter saturates at 2^CNT_W-1.
    - When the window counter equals CPT_MAX, go to EMIT; an event arriving in that same cycle is not counted.
    - CPT_MAX = 0 closes the window immediately and reports a count of 0.
  - EMIT: emit 3 words, in order:
    - channel, zero-extended;
    - DAC code, zero-extended;
    - trigger count, zero-extended.
  - NEXT:
    - Next DAC code = DAC + step, computed at DAC_W+1 bits. If the result is <= DAC_Stop and has no carry, go to LOAD with the new code.
    - Otherwise, in all-channel mode with channel < NCHN-1: increment the channel, reload DAC_Start, go to LOAD.
    - Otherwise, go to TRAILER.
  - TRAILER: emit 16'hFF46, then go to DONE.
  - ABORT: emit 16'hFFEE, then go to DONE.
  - DONE: Test_Done = 1, Busy = 0. Stay until the next start edge.
- Output handshake:
  - A word transfers on the cycle where Data_Valid & Data_Ready are both 1.
  - Data_Out and Data_Valid are registered and hold stable until accepted. The FSM stalls while Data_Ready = 0.
  - No words are lost or duplicated.
- Reset mid-scan aborts immediately to the reset state; no trailer is emitted.

Test Plan:
- Single channel: Single_Chn = 5, Ctest_or_Input = 1, DAC 100..102 step 1, CPT_MAX = 10, 4 trigger falls per window -> CTest_Chn_Out = 1<<5, 3 Param_Load pulses, stream FF45, [5,100,4], [5,101,4], [5,102,4], FF46, then Test_Done = 1.
- All-channel: NCHN = 4, DAC 0..1023 step 512 -> 8 points in order (ch0 dac0), (ch0 dac512), (ch1 dac0), ... (ch3 dac512); mask walks 0001, 0010, 0100, 1000.
- DAC 1020..1023 step 8 (DAC_W = 10) -> exactly one point at 1020, no wrap; DAC_Start = 5, DAC_Stop = 3 -> FF45, FF46 only.
- Back-pressure: Data_Ready held 0 for 20 cycles mid-EMIT -> Data_Out and Data_Valid stable throughout, no lost or duplicated words; trigger count 70000 with CNT_W = 16 reads FFFF.
- Config_Done never asserted, CFG_TIMEOUT = 100 -> FF45, FFEE after 100 cycles, Test_Done = 1; Test_Start edge while Busy is ignored.
- reset pulse during COUNT -> all outputs 0, Busy = 0; a new start then runs a full scan correctly.
